instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage ahead of the immediate generator and control decode.
//  - Owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake
//    with variable latency.
//  - Holds each fetched instruction stable until the consumer accepts it.
//  - Classifies the opcode into the R/I/S/B/U/J type code that the immediate generator uses
//    as its type input.
//  - Accepts branch/jump redirects from execute.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC fetched first after reset
// PORTS
//  clk_i          in   1    clock, all state on rising edge
//  rst_i          in   1    synchronous, active-high reset
//  stall_i        in   1    consumer not ready; hold current instruction
//  redirect_i     in   1    taken branch/jump this cycle
//  redirect_pc_i  in   32   target PC when redirect_i=1
//  imem_req_o     out  1    instruction memory request
//  imem_addr_o    out  32   request address (word aligned)
//  imem_ack_i     in   1    memory returns data this cycle
//  imem_rdata_i   in   32   returned instruction word
//  instr_o        out  32   held instruction; [31:7] feeds immediate generator
//  pc_o           out  32   PC of instr_o
//  type_o         out  3    instruction type code from shared package
//  instr_vld_o    out  1    instr_o/pc_o/type_o valid
//  misalign_o     out  1    sticky: redirect target not word aligned
// BEHAVIOUR
//  Reset values:
//  - imem_req_o=0, imem_addr_o=RESET_PC, pc_o=RESET_PC.
//  - instr_o=32'h0000_0013 (NOP), type_o=ITYPE, instr_vld_o=0, misalign_o=0.
//  - State=START; fetch_pc=RESET_PC; redir_pend=0.
//  FSM states: START, REQ, HOLD, FAULT.
//  START: one cycle after reset release -> REQ. imem_req_o=0.
//  REQ:
//  - imem_req_o=1, imem_addr_o=fetch_pc. Req and addr stay constant until ack (memory rule).
//  - On ack with redir_pend=0: instr_o<=rdata, pc_o<=fetch_pc, type_o<=class(rdata[6:0]),
//    instr_vld_o<=1 -> HOLD. Minimum latency is req to vld in 1 cycle.
//  - redirect_i in REQ without ack: record redir_pend=1 and the target. The outstanding
//    request still completes.
//  - On the ack that follows a pending redirect: discard data, fetch_pc<=target,
//    redir_pend<=0, stay REQ (new address next cycle).
//  - redirect_i coinciding with ack: data discarded, same as above.
//  HOLD:
//  - imem_req_o=0. Outputs are stable while stall_i=1.
//  - stall_i=0: instr_vld_o<=0, fetch_pc<=pc_o+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
//    -> REQ.
//  - redirect_i=1 (with or without stall): instr_vld_o<=0, fetch_pc<=redirect_pc_i -> REQ.
//    Redirect has priority over stall.
//  Misaligned redirect (redirect_pc_i[1:0]!=0, any state):
//  - misalign_o<=1, instr_vld_o<=0.
//  - If a request is outstanding, wait for its ack (discard), then FAULT; otherwise -> FAULT.
//  FAULT:
//  - No requests; only an aligned redirect leaves, to REQ with misalign_o<=0.
//  - Reset also clears FAULT.
//  rst_i mid-request: return to reset values immediately. A late ack after reset is ignored,
//  because data is captured only in REQ.
//  Type classification (opcode[6:0] -> type_o):
//  - 0110011 -> RTYPE.
//  - 0010011, 0000011, 1100111, 1110011, 0001111 -> ITYPE.
//  - 0100011 -> STYPE; 1100011 -> BTYPE.
//  - 0110111, 0010111 -> UTYPE; 1101111 -> JTYPE.
//  - Other opcodes -> ILLTYPE (3'b111); instruction is still presented with vld.
// STRUCTURE
//  Shared package rv32_pkg:
//  - Type codes RTYPE=0, ITYPE=1, STYPE=2, BTYPE=3, UTYPE=4, JTYPE=5, ILLTYPE=7.
//  - Opcode constants.
//  - NOP constant 32'h0000_0013.
//  - typedef enum fetch_state_e.
//  Sub-module instr_type_dec: purely combinational opcode -> type_o; also reused by the
//  control unit. FSM, PC register and instruction register stay in instr_fetch.
// TESTING
//  1. Reset, ack after 1 cycle, rdata=32'h00500093 -> addr 0, pc_o=0, type_o=ITYPE, vld=1.
//     stall_i=0 -> next req addr=4.
//  2. ack delayed 5 cycles -> req high and addr steady all 5 cycles. stall_i=1 for 3 cycles
//     in HOLD -> instr_o unchanged, no req.
//  3. redirect_i=1, pc=32'h0000_0100 while REQ (ack 2 cycles later, rdata=32'hDEADBEEF)
//     -> data dropped, vld stays 0, next req addr=32'h100.
//  4. HOLD with stall_i=1 and redirect to 32'h40 -> vld drops, next req addr=32'h40.
//  5. Redirect to 32'h0000_0102 -> misalign_o=1, no further req. Redirect to 32'h200
//     -> misalign_o=0, req addr=32'h200.
//  6. Opcode sweep: 32'h00000033 R, 32'h00002023 S, 32'h00000063 B, 32'h00000037 U,
//     32'h0000006F J, 32'h0000007F ILL.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants: instruction type codes, opcodes, NOP and the
// fetch FSM state encoding used by the fetch stage and the control unit.
package rv32_pkg;

  typedef enum logic [2:0] {
    RTYPE   = 3'd0,
    ITYPE   = 3'd1,
    STYPE   = 3'd2,
    BTYPE   = 3'd3,
    UTYPE   = 3'd4,
    JTYPE   = 3'd5,
    ILLTYPE = 3'd7
  } instr_type_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Sequential fetch address; the 32-bit add wraps 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave). Request and address hold steady until ack.
interface instr_fetch_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/instr_type_dec.sv
// Combinational opcode classifier producing the immediate-format type code;
// shared by the fetch stage and the control unit.
module instr_type_dec
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] type_o
);

  always_comb begin
    type_o = ILLTYPE;
    case (opcode_i)
      OPC_OP:       type_o = RTYPE;
      OPC_OP_IMM,
      OPC_LOAD,
      OPC_JALR,
      OPC_SYSTEM,
      OPC_MISC_MEM: type_o = ITYPE;
      OPC_STORE:    type_o = STYPE;
      OPC_BRANCH:   type_o = BTYPE;
      OPC_LUI,
      OPC_AUIPC:    type_o = UTYPE;
      OPC_JAL:      type_o = JTYPE;
      default:      type_o = ILLTYPE;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a variable-latency req/ack bus, holds
// the fetched word until the consumer takes it, and handles redirects/faults.
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr_o,
  output logic [31:0]          pc_o,
  output logic [2:0]           type_o,
  output logic                 instr_vld_o,
  output logic                 misalign_o
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_fetch_pc,   w_fetch_pc_next;
  logic        r_redir_pend, w_redir_pend_next;
  logic [31:0] r_redir_pc,   w_redir_pc_next;
  logic        r_fault_pend, w_fault_pend_next;
  logic [31:0] r_instr,      w_instr_next;
  logic [31:0] r_pc,         w_pc_next;
  logic [2:0]  r_type,       w_type_next;
  logic        r_vld,        w_vld_next;
  logic        r_misalign,   w_misalign_next;

  logic [2:0]  w_rdata_type;
  logic        w_redir_ok;
  logic        w_redir_bad;

  instr_type_dec u_type_dec (
    .opcode_i (imem.imem_rdata_i[6:0]),
    .type_o   (w_rdata_type)
  );

  assign w_redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign w_redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);

  assign imem.imem_req_o  = (r_state == ST_REQ);
  assign imem.imem_addr_o = r_fetch_pc;

  assign instr_o     = r_instr;
  assign pc_o        = r_pc;
  assign type_o      = r_type;
  assign instr_vld_o = r_vld;
  assign misalign_o  = r_misalign;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_START;
      r_fetch_pc   <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= RESET_PC;
      r_fault_pend <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pc         <= RESET_PC;
      r_type       <= ITYPE;
      r_vld        <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_redir_pend <= w_redir_pend_next;
      r_redir_pc   <= w_redir_pc_next;
      r_fault_pend <= w_fault_pend_next;
      r_instr      <= w_instr_next;
      r_pc         <= w_pc_next;
      r_type       <= w_type_next;
      r_vld        <= w_vld_next;
      r_misalign   <= w_misalign_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_fetch_pc_next   = r_fetch_pc;
    w_redir_pend_next = r_redir_pend;
    w_redir_pc_next   = r_redir_pc;
    w_fault_pend_next = r_fault_pend;
    w_instr_next      = r_instr;
    w_pc_next         = r_pc;
    w_type_next       = r_type;
    w_vld_next        = r_vld;
    w_misalign_next   = r_misalign;

    case (r_state)
      ST_START: begin
        w_state_next = ST_REQ;
        if (w_redir_bad) begin
          w_misalign_next = 1'b1;
          w_state_next    = ST_FAULT;
        end else if (w_redir_ok) begin
          w_fetch_pc_next = redirect_pc_i;
        end
      end

      ST_REQ: begin
        if (imem.imem_ack_i) begin
          w_redir_pend_next = 1'b0;
          w_fault_pend_next = 1'b0;
          if (w_redir_bad) begin
            w_misalign_next = 1'b1;
            w_vld_next      = 1'b0;
            w_state_next    = ST_FAULT;
          end else if (w_redir_ok) begin
            w_fetch_pc_next = redirect_pc_i;
            w_misalign_next = 1'b0;
          end else if (r_fault_pend) begin
            w_state_next = ST_FAULT;
          end else if (r_redir_pend) begin
            w_fetch_pc_next = r_redir_pc;
          end else begin
            w_instr_next = imem.imem_rdata_i;
            w_pc_next    = r_fetch_pc;
            w_type_next  = w_rdata_type;
            w_vld_next   = 1'b1;
            w_state_next = ST_HOLD;
          end
        end else if (w_redir_bad) begin
          // The outstanding request must still complete before faulting.
          w_fault_pend_next = 1'b1;
          w_redir_pend_next = 1'b0;
          w_misalign_next   = 1'b1;
          w_vld_next        = 1'b0;
        end else if (w_redir_ok) begin
          // A later aligned redirect supersedes an earlier pending fault.
          w_redir_pend_next = 1'b1;
          w_redir_pc_next   = redirect_pc_i;
          w_fault_pend_next = 1'b0;
          w_misalign_next   = 1'b0;
        end
      end

      ST_HOLD: begin
        if (w_redir_bad) begin
          w_vld_next      = 1'b0;
          w_misalign_next = 1'b1;
          w_state_next    = ST_FAULT;
        end else if (w_redir_ok) begin
          w_vld_next      = 1'b0;
          w_fetch_pc_next = redirect_pc_i;
          w_state_next    = ST_REQ;
        end else if (!stall_i) begin
          w_vld_next      = 1'b0;
          w_fetch_pc_next = next_word_pc(r_pc);
          w_state_next    = ST_REQ;
        end
      end

      ST_FAULT: begin
        if (w_redir_ok) begin
          w_fetch_pc_next = redirect_pc_i;
          w_misalign_next = 1'b0;
          w_state_next    = ST_REQ;
        end
      end

      default: w_state_next = ST_START;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a bench-driven memory serves requests with
// chosen latency; captured words are checked against a scoreboard queue.
module tb_instr_fetch;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  typ;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  typ;
  logic        vld;
  logic        misalign;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem_bus),
    .instr_o       (instr),
    .pc_o          (pc),
    .type_o        (typ),
    .instr_vld_o   (vld),
    .misalign_o    (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic [2:0] e_typ);
    exp_t e;
    e.instr = e_instr;
    e.pc    = e_pc;
    e.typ   = e_typ;
    sb.push_back(e);
  endtask

  // Wait for a request, check it stays steady for n_wait cycles, then ack.
  // redir_at selects the wait cycle carrying a redirect (n_wait = with the ack).
  task automatic serve(input string tag, input int n_wait, input logic [31:0] exp_addr,
                       input logic [31:0] data, input int redir_at,
                       input logic [31:0] redir_pc);
    int t;
    t = 0;
    while (imem_bus.imem_req_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_req"}, {31'd0, imem_bus.imem_req_o}, 32'd1);
    chk({tag, "_addr"}, imem_bus.imem_addr_o, exp_addr);
    for (int i = 0; i < n_wait; i++) begin
      if (i == redir_at) begin
        redirect    = 1'b1;
        redirect_pc = redir_pc;
      end
      @(negedge clk);
      redirect = 1'b0;
      chk({tag, "_req_held"}, {31'd0, imem_bus.imem_req_o}, 32'd1);
      chk({tag, "_addr_held"}, imem_bus.imem_addr_o, exp_addr);
    end
    if (redir_at == n_wait) begin
      redirect    = 1'b1;
      redirect_pc = redir_pc;
    end
    imem_bus.imem_ack_i   = 1'b1;
    imem_bus.imem_rdata_i = data;
    @(negedge clk);
    imem_bus.imem_ack_i   = 1'b0;
    imem_bus.imem_rdata_i = 32'd0;
    redirect              = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    int   t;
    t = 0;
    while (vld !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_vld"}, {31'd0, vld}, 32'd1);
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: observed empty scoreboard, required a queued entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.instr);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_type"}, {29'd0, typ}, {29'd0, e.typ});
      $display("[TB] %s instr=%h pc=%h type=%0d", tag, instr, pc, typ);
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  initial begin
    n_tests               = 0;
    n_fail                = 0;
    rst                   = 1'b1;
    stall                 = 1'b0;
    redirect              = 1'b0;
    redirect_pc           = 32'd0;
    imem_bus.imem_ack_i   = 1'b0;
    imem_bus.imem_rdata_i = 32'd0;
    repeat (2) @(negedge clk);

    chk("rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    chk("rst_addr", imem_bus.imem_addr_o, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_type", {29'd0, typ}, {29'd0, T_I});
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;

    // 1: single-cycle ack, then sequential advance
    expect_instr(32'h0050_0093, 32'h0, T_I);
    serve("t1", 0, 32'h0, 32'h0050_0093, -1, 32'd0);
    check_out("t1");
    @(negedge clk);
    chk("t1_vld_drop", {31'd0, vld}, 32'd0);
    chk("t1_next_addr", imem_bus.imem_addr_o, 32'h4);

    // 2: long latency, then stall in HOLD
    stall = 1'b1;
    expect_instr(32'h0040_2103, 32'h4, T_I);
    serve("t2", 5, 32'h4, 32'h0040_2103, -1, 32'd0);
    check_out("t2");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_instr", instr, 32'h0040_2103);
      chk("t2_stall_noreq", {31'd0, imem_bus.imem_req_o}, 32'd0);
      chk("t2_stall_vld", {31'd0, vld}, 32'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t2_next_addr", imem_bus.imem_addr_o, 32'h8);

    // 3: redirect during outstanding request drops the returned data
    stall = 1'b1;
    serve("t3", 2, 32'h8, 32'hDEAD_BEEF, 0, 32'h0000_0100);
    chk("t3_drop_vld", {31'd0, vld}, 32'd0);
    expect_instr(32'h0000_0033, 32'h100, T_R);
    serve("t3b", 0, 32'h100, 32'h0000_0033, -1, 32'd0);
    check_out("t3b");

    // 4: redirect beats stall in HOLD
    pulse_redirect(32'h0000_0040);
    chk("t4_vld", {31'd0, vld}, 32'd0);
    expect_instr(32'h0000_2023, 32'h40, T_S);
    serve("t4", 0, 32'h40, 32'h0000_2023, -1, 32'd0);
    check_out("t4");

    // 5: misaligned redirect faults, aligned redirect recovers
    pulse_redirect(32'h0000_0102);
    chk("t5_misalign", {31'd0, misalign}, 32'd1);
    chk("t5_vld", {31'd0, vld}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_fault_noreq", {31'd0, imem_bus.imem_req_o}, 32'd0);
    end
    pulse_redirect(32'h0000_0200);
    chk("t5_clear", {31'd0, misalign}, 32'd0);
    expect_instr(32'h0000_0063, 32'h200, T_B);
    serve("t5", 0, 32'h200, 32'h0000_0063, -1, 32'd0);
    check_out("t5");
    stall = 1'b0;

    // 6: opcode sweep on sequential fetches
    expect_instr(32'h0000_0037, 32'h204, T_U);
    serve("t6u", 0, 32'h204, 32'h0000_0037, -1, 32'd0);
    check_out("t6u");
    expect_instr(32'h0000_006F, 32'h208, T_J);
    serve("t6j", 0, 32'h208, 32'h0000_006F, -1, 32'd0);
    check_out("t6j");
    expect_instr(32'h0000_007F, 32'h20C, T_ILL);
    serve("t6ill", 0, 32'h20C, 32'h0000_007F, -1, 32'd0);
    check_out("t6ill");
    expect_instr(32'h0000_8067, 32'h210, T_I);
    serve("t6jalr", 0, 32'h210, 32'h0000_8067, -1, 32'd0);
    check_out("t6jalr");

    // 7: redirect coincident with ack, then PC wrap at the top of memory
    serve("t7", 0, 32'h214, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFC);
    chk("t7_drop_vld", {31'd0, vld}, 32'd0);
    expect_instr(32'h0000_0013, 32'hFFFF_FFFC, T_I);
    serve("t7top", 0, 32'hFFFF_FFFC, 32'h0000_0013, -1, 32'd0);
    check_out("t7top");
    expect_instr(32'h0010_0093, 32'h0, T_I);
    serve("t7wrap", 0, 32'h0, 32'h0010_0093, -1, 32'd0);
    check_out("t7wrap");

    // 8: misaligned redirect while a request is outstanding
    serve("t8", 2, 32'h4, 32'h0000_0033, 0, 32'h0000_0301);
    chk("t8_misalign", {31'd0, misalign}, 32'd1);
    chk("t8_vld", {31'd0, vld}, 32'd0);
    chk("t8_noreq", {31'd0, imem_bus.imem_req_o}, 32'd0);

    // 9: reset mid-request, late ack ignored
    pulse_redirect(32'h0000_0080);
    chk("t9_req", {31'd0, imem_bus.imem_req_o}, 32'd1);
    chk("t9_addr", imem_bus.imem_addr_o, 32'h80);
    rst = 1'b1;
    @(negedge clk);
    chk("t9_rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    chk("t9_rst_addr", imem_bus.imem_addr_o, 32'h0);
    chk("t9_rst_misalign", {31'd0, misalign}, 32'd0);
    chk("t9_rst_instr", instr, 32'h0000_0013);
    rst                   = 1'b0;
    imem_bus.imem_ack_i   = 1'b1;
    imem_bus.imem_rdata_i = 32'h0000_0033;
    @(negedge clk);
    imem_bus.imem_ack_i   = 1'b0;
    imem_bus.imem_rdata_i = 32'd0;
    chk("t9_late_ack_vld", {31'd0, vld}, 32'd0);
    expect_instr(32'h0000_0037, 32'h0, T_U);
    serve("t9", 0, 32'h0, 32'h0000_0037, -1, 32'd0);
    check_out("t9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
